// File: rtl/biker_frame_sequencer.sv
// biker_frame_sequencer
//   Per-pixel draw controller for the 32x32 biker sprite. Picks the frame
//   (straight / turn-right / turn-left mirrored) once per video frame on
//   startOfFrame, then fetches, keys and registers the sprite pixel.
// Ports:
//   clk, resetN               pixel clock, async active-low reset
//   startOfFrame              one-cycle pulse at the start of each video frame
//   turn_left_req/right_req   turn request levels
//   InsideRectangle           current pixel is inside the sprite box
//   offsetX, offsetY          column/row inside the box (0..31)
//   object_colors             straight bitmap [row][col][colour]
//   object_colors_turn        right-turn bitmap, mirrored for left turns
//   drawingRequest, RGBout    registered draw flag and RGB332 colour
//   frame_state               0 STRAIGHT, 1 TURN_R, 2 TURN_L
module biker_frame_sequencer #(
   parameter int unsigned TURN_HOLD_FRAMES     = 8,
   parameter logic [7:0]  TRANSPARENT_ENCODING = 8'hFF
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic                    turn_left_req,
   input  logic                    turn_right_req,
   input  logic                    InsideRectangle,
   input  logic [4:0]              offsetX,
   input  logic [4:0]              offsetY,
   input  logic [0:31][0:31][7:0]  object_colors,
   input  logic [0:31][0:31][7:0]  object_colors_turn,
   output logic                    drawingRequest,
   output logic [7:0]              RGBout,
   output logic [1:0]              frame_state
);

   typedef enum logic [1:0] {
      STRAIGHT = 2'd0,
      TURN_R   = 2'd1,
      TURN_L   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD = 8'(TURN_HOLD_FRAMES);

   state_t     state;
   logic [7:0] hold_cnt;
   logic       lat_l;
   logic       lat_r;
   logic       eff_l;
   logic       eff_r;
   logic       go_l;
   logic       go_r;
   logic [4:0] col;
   logic [7:0] pix;

   // Requests seen in the startOfFrame cycle itself count toward this decision.
   assign eff_l = lat_l | turn_left_req;
   assign eff_r = lat_r | turn_right_req;
   assign go_l  = eff_l & ~eff_r;
   assign go_r  = eff_r & ~eff_l;

   assign frame_state = state;

   // Pixel fetch uses the pre-update state, so a new frame applies from the
   // cycle after the startOfFrame pulse.
   always_comb begin
      col = offsetX;
      pix = object_colors[offsetY][offsetX];
      case (state)
         TURN_R: begin
            col = offsetX;
            pix = object_colors_turn[offsetY][col];
         end
         TURN_L: begin
            col = 5'd31 - offsetX;
            pix = object_colors_turn[offsetY][col];
         end
         default: begin
            col = offsetX;
            pix = object_colors[offsetY][col];
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state          <= STRAIGHT;
         hold_cnt       <= '0;
         lat_l          <= 1'b0;
         lat_r          <= 1'b0;
         drawingRequest <= 1'b0;
         RGBout         <= '0;
      end else begin
         drawingRequest <= InsideRectangle && (pix != TRANSPARENT_ENCODING);
         RGBout         <= pix;

         if (startOfFrame) begin
            lat_l <= 1'b0;
            lat_r <= 1'b0;
            case (state)
               STRAIGHT: begin
                  if (go_r) begin
                     state    <= TURN_R;
                     hold_cnt <= HOLD;
                  end else if (go_l) begin
                     state    <= TURN_L;
                     hold_cnt <= HOLD;
                  end
               end
               TURN_R: begin
                  if (go_r) begin
                     hold_cnt <= HOLD;
                  end else if (go_l) begin
                     state    <= TURN_L;
                     hold_cnt <= HOLD;
                  end else if (hold_cnt <= 8'd1) begin
                     // <= 1 rather than == 1 keeps the counter from wrapping
                     state    <= STRAIGHT;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt - 8'd1;
                  end
               end
               TURN_L: begin
                  if (go_l) begin
                     hold_cnt <= HOLD;
                  end else if (go_r) begin
                     state    <= TURN_R;
                     hold_cnt <= HOLD;
                  end else if (hold_cnt <= 8'd1) begin
                     state    <= STRAIGHT;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt - 8'd1;
                  end
               end
               default: begin
                  state    <= STRAIGHT;
                  hold_cnt <= '0;
               end
            endcase
         end else begin
            lat_l <= lat_l | turn_left_req;
            lat_r <= lat_r | turn_right_req;
         end
      end
   end

endmodule

// File: tb/tb_biker_frame_sequencer.sv
// tb_biker_frame_sequencer
//   Directed bench for biker_frame_sequencer. Two instances (hold 8 and hold 1)
//   share stimulus; a frame-level model predicts state and pixel outputs and is
//   compared on every falling edge, alongside hand-computed literal checks.
module tb_biker_frame_sequencer;

   logic                   clk = 1'b0;
   logic                   resetN;
   logic                   startOfFrame;
   logic                   turn_left_req;
   logic                   turn_right_req;
   logic                   InsideRectangle;
   logic [4:0]             offsetX;
   logic [4:0]             offsetY;
   logic [0:31][0:31][7:0] sbm;
   logic [0:31][0:31][7:0] tbm;

   logic       dr0, dr1;
   logic [7:0] rgb0, rgb1;
   logic [1:0] fs0, fs1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   biker_frame_sequencer #(.TURN_HOLD_FRAMES(8), .TRANSPARENT_ENCODING(8'hFF)) dut0 (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .turn_left_req(turn_left_req), .turn_right_req(turn_right_req),
      .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
      .object_colors(sbm), .object_colors_turn(tbm),
      .drawingRequest(dr0), .RGBout(rgb0), .frame_state(fs0));

   biker_frame_sequencer #(.TURN_HOLD_FRAMES(1), .TRANSPARENT_ENCODING(8'hFF)) dut1 (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .turn_left_req(turn_left_req), .turn_right_req(turn_right_req),
      .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
      .object_colors(sbm), .object_colors_turn(tbm),
      .drawingRequest(dr1), .RGBout(rgb1), .frame_state(fs1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   // State after the k-th startOfFrame is the direction of the latest frame with
   // exactly one request, provided fewer than HOLD frames have passed since it.
   int         hold_of [2] = '{8, 1};
   int         m_state [2] = '{0, 0};
   bit         e_dr    [2] = '{1'b0, 1'b0};
   logic [7:0] e_rgb   [2] = '{8'h00, 8'h00};
   bit         m_lat_l = 1'b0;
   bit         m_lat_r = 1'b0;
   int         sof_k = 0;
   int         last_k = 0;
   int         last_dir = 0;
   bit         valid = 1'b0;

   always @(posedge clk or negedge resetN) begin : mdl
      int c;
      logic [7:0] p;
      bit el, er;
      if (!resetN) begin
         for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            e_dr[i]    = 1'b0;
            e_rgb[i]   = 8'h00;
         end
         m_lat_l = 1'b0;
         m_lat_r = 1'b0;
         valid   = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            c = (m_state[i] == 2) ? 31 - int'(offsetX) : int'(offsetX);
            p = (m_state[i] == 0) ? sbm[offsetY][c] : tbm[offsetY][c];
            e_rgb[i] = p;
            e_dr[i]  = InsideRectangle && (p != 8'hFF);
         end
         if (startOfFrame) begin
            el = m_lat_l | turn_left_req;
            er = m_lat_r | turn_right_req;
            sof_k++;
            if (er && !el) begin
               last_dir = 1; last_k = sof_k; valid = 1'b1;
            end else if (el && !er) begin
               last_dir = 2; last_k = sof_k; valid = 1'b1;
            end
            for (int i = 0; i < 2; i++)
               m_state[i] = (valid && (sof_k - last_k) < hold_of[i]) ? last_dir : 0;
            m_lat_l = 1'b0;
            m_lat_r = 1'b0;
         end else begin
            m_lat_l = m_lat_l | turn_left_req;
            m_lat_r = m_lat_r | turn_right_req;
         end
      end
   end

   always @(negedge clk) begin
      chk("model_fs0",  32'(fs0),  32'(m_state[0]));
      chk("model_dr0",  32'(dr0),  32'(e_dr[0]));
      chk("model_rgb0", 32'(rgb0), 32'(e_rgb[0]));
      chk("model_fs1",  32'(fs1),  32'(m_state[1]));
      chk("model_dr1",  32'(dr1),  32'(e_dr[1]));
      chk("model_rgb1", 32'(rgb1), 32'(e_rgb[1]));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         idle(3);
         sof();
      end
   endtask

   initial begin
      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 32; x++) begin
            sbm[y][x] = 8'((y % 4) * 32 + x);
            tbm[y][x] = 8'(128 + (y % 2) * 32 + x);
         end
      sbm[0][0]  = 8'hFF;
      sbm[1][15] = 8'h6D;
      sbm[5][5]  = 8'hFF;
      tbm[1][18] = 8'h6D;
      tbm[1][13] = 8'hFF;
      tbm[2][2]  = 8'hFF;

      resetN = 1'b0;
      startOfFrame = 1'b0;
      turn_left_req = 1'b0;
      turn_right_req = 1'b0;
      InsideRectangle = 1'b1;
      offsetX = 5'd15;
      offsetY = 5'd1;
      idle(2);
      chk("rst_fs", 32'(fs0), 0);
      chk("rst_dr", 32'(dr0), 0);
      chk("rst_rgb", 32'(rgb0), 32'h00);

      // idle straight frame
      resetN = 1'b1;
      step();
      chk("idle_fs", 32'(fs0), 0);
      chk("idle_dr", 32'(dr0), 1);
      chk("idle_rgb", 32'(rgb0), 32'h6D);
      offsetX = 5'd0; offsetY = 5'd0;
      step();
      chk("transp_dr", 32'(dr0), 0);
      chk("transp_rgb", 32'(rgb0), 32'hFF);
      offsetX = 5'd15; offsetY = 5'd1; InsideRectangle = 1'b0;
      step();
      chk("outside_dr", 32'(dr0), 0);
      chk("outside_rgb", 32'(rgb0), 32'h6D);
      InsideRectangle = 1'b1;

      // right turn: latched mid-frame, applied at next startOfFrame
      turn_right_req = 1'b1;
      idle(3);
      turn_right_req = 1'b0;
      idle(2);
      chk("right_wait_fs", 32'(fs0), 0);
      sof();
      chk("right_fs", 32'(fs0), 1);
      chk("right_fs_h1", 32'(fs1), 1);
      offsetX = 5'd18; offsetY = 5'd1;
      step();
      chk("right_rgb", 32'(rgb0), 32'h6D);
      chk("right_dr", 32'(dr0), 1);
      for (int f = 1; f <= 8; f++) begin
         frames(1);
         if (f == 1) chk("h1_expire_fs", 32'(fs1), 0);
         chk("right_hold_fs", 32'(fs0), (f < 8) ? 1 : 0);
      end

      // left turn with mirrored bitmap
      turn_left_req = 1'b1;
      idle(2);
      sof();
      turn_left_req = 1'b0;
      chk("left_fs", 32'(fs0), 2);
      offsetX = 5'd13; offsetY = 5'd1;
      step();
      chk("left_rgb", 32'(rgb0), 32'h6D);
      chk("left_dr", 32'(dr0), 1);
      offsetX = 5'd18;
      step();
      chk("left_transp_dr", 32'(dr0), 0);
      frames(8);
      chk("left_end_fs", 32'(fs0), 0);

      // conflicts and same-cycle requests
      turn_left_req = 1'b1; turn_right_req = 1'b1;
      idle(2);
      sof();
      turn_left_req = 1'b0; turn_right_req = 1'b0;
      chk("both_fs", 32'(fs0), 0);
      turn_right_req = 1'b1;
      sof();
      turn_right_req = 1'b0;
      chk("sof_cycle_req_fs", 32'(fs0), 1);
      turn_left_req = 1'b1;
      idle(1);
      sof();
      turn_left_req = 1'b0;
      chk("r_to_l_fs", 32'(fs0), 2);
      frames(7);
      chk("reload_fs7", 32'(fs0), 2);
      frames(1);
      chk("reload_fs8", 32'(fs0), 0);

      // hold extension
      turn_right_req = 1'b1;
      sof();
      turn_right_req = 1'b0;
      repeat (20) begin
         idle(2);
         turn_right_req = 1'b1;
         step();
         turn_right_req = 1'b0;
         idle(2);
         sof();
         chk("extend_fs", 32'(fs0), 1);
      end
      frames(7);
      chk("extend_fs7", 32'(fs0), 1);
      frames(1);
      chk("extend_fs8", 32'(fs0), 0);

      // async reset mid-turn (hold count 5)
      turn_left_req = 1'b1;
      sof();
      turn_left_req = 1'b0;
      frames(3);
      offsetX = 5'd13; offsetY = 5'd1;
      step();
      chk("pre_rst_fs", 32'(fs0), 2);
      chk("pre_rst_rgb", 32'(rgb0), 32'h6D);
      @(posedge clk);
      #2;
      resetN = 1'b0;
      #1;
      chk("arst_fs", 32'(fs0), 0);
      chk("arst_dr", 32'(dr0), 0);
      chk("arst_rgb", 32'(rgb0), 32'h00);
      step();
      resetN = 1'b1;
      step();
      chk("post_rst_fs", 32'(fs0), 0);
      chk("post_rst_rgb", 32'(rgb0), 32'h2D);
      chk("post_rst_dr", 32'(dr0), 1);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
